// File: rtl/bip_cpu_core.sv
// BIP accumulator CPU core: three-state control FSM (RUN / WAIT_DM / HALT) with
// async-read program memory, ready-stalled data memory port and saturating cycle counter.
module bip_cpu_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [5+ADDR_W-1:0] instruction,
  output logic [ADDR_W-1:0]   addr_pm,
  input  logic [DATA_W-1:0]   dm_rdata,
  input  logic                dm_ready,
  output logic [ADDR_W-1:0]   addr_dm,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_rd,
  output logic                dm_wr,
  output logic [DATA_W-1:0]   acc,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [1:0] {RUN, WAIT_DM, HALT} state_t;

  localparam logic [4:0] OP_HLT  = 5'd0,  OP_STO  = 5'd1,  OP_LD   = 5'd2,  OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4,  OP_ADDI = 5'd5,  OP_SUB  = 5'd6,  OP_SUBI = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8,  OP_ANDI = 5'd9,  OP_OR   = 5'd10, OP_ORI  = 5'd11;
  localparam logic [4:0] OP_XOR  = 5'd12, OP_XORI = 5'd13, OP_JMP  = 5'd14, OP_BZ   = 5'd15;
  localparam logic [4:0] OP_BNZ  = 5'd16;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc_nx;
  logic [DATA_W-1:0]   acc_nx;
  logic [4:0]          ir_op;
  logic [ADDR_W-1:0]   ir_opnd;
  logic                ir_ld;

  logic [4:0]          op;
  logic [ADDR_W-1:0]   opnd;
  logic                active, is_mem;
  logic [DATA_W-1:0]   sx_opnd, b_opnd, result;

  always_comb begin
    op   = instruction[5+ADDR_W-1:ADDR_W];
    opnd = instruction[ADDR_W-1:0];
    if (state == WAIT_DM) begin
      op   = ir_op;
      opnd = ir_opnd;
    end

    active  = (state == WAIT_DM) || ((state == RUN) && en);
    is_mem  = op inside {OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    sx_opnd = DATA_W'($signed(opnd));
    // odd opcodes in the ALU group are the immediate forms
    b_opnd  = op[0] ? sx_opnd : dm_rdata;

    case (op)
      OP_LD,  OP_LDI:  result = b_opnd;
      OP_ADD, OP_ADDI: result = acc + b_opnd;
      OP_SUB, OP_SUBI: result = acc - b_opnd;
      OP_AND, OP_ANDI: result = acc & b_opnd;
      OP_OR,  OP_ORI:  result = acc | b_opnd;
      OP_XOR, OP_XORI: result = acc ^ b_opnd;
      default:         result = acc;
    endcase

    dm_rd    = active && is_mem && (op != OP_STO);
    dm_wr    = active && (op == OP_STO);
    addr_dm  = (dm_rd || dm_wr) ? opnd : '0;
    dm_wdata = acc;
    halted   = (state == HALT);

    state_nx = state;
    pc_nx    = addr_pm;
    acc_nx   = acc;
    ir_ld    = 1'b0;
    if (active) begin
      if (is_mem && !dm_ready) begin
        state_nx = WAIT_DM;
        ir_ld    = (state == RUN);
      end else begin
        state_nx = RUN;
        pc_nx    = addr_pm + ADDR_W'(1);
        acc_nx   = result;
        case (op)
          OP_HLT: begin
            state_nx = HALT;
            pc_nx    = addr_pm;
          end
          OP_JMP: pc_nx = opnd;
          OP_BZ:  if (acc == '0) pc_nx = opnd;
          OP_BNZ: if (acc != '0) pc_nx = opnd;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      addr_pm     <= '0;
      acc         <= '0;
      ir_op       <= '0;
      ir_opnd     <= '0;
      cycle_count <= '0;
    end else begin
      state   <= state_nx;
      addr_pm <= pc_nx;
      acc     <= acc_nx;
      if (ir_ld) begin
        ir_op   <= op;
        ir_opnd <= opnd;
      end
      if (active && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
